// File: rtl/cache_nway_wb_pkg.sv
// Shared types for the N-way write-back cache.
// Holds only the controller state encoding; width localparams are parameter-derived and stay
// inside the modules that use them.
package cache_nway_wb_pkg;

  typedef enum logic [1:0] {
    StCheck,
    StWriteback,
    StFill
  } cache_state_t;

endpackage

// File: rtl/cache_nway_wb_plru.sv
// Tree pseudo-LRU for one set (combinational).
// Ports:
//   tree_i   - current tree bits (Ways-1), heap order: node n has children 2n+1 / 2n+2
//   way_i    - way being accessed
//   tree_o   - tree bits after accessing way_i (every node on its path points away from it)
//   victim_o - way reached by following the current tree bits from the root
// A node bit of 1 steers towards the right subtree, 0 towards the left.
module cache_nway_wb_plru #(
  parameter int unsigned Ways = 4
) (
  input  logic [Ways-2:0]         tree_i,
  input  logic [$clog2(Ways)-1:0] way_i,
  output logic [Ways-2:0]         tree_o,
  output logic [$clog2(Ways)-1:0] victim_o
);

  localparam int unsigned WayW = $clog2(Ways);

  always_comb begin
    int unsigned node;
    node   = 0;
    tree_o = tree_i;
    // Way bits, MSB first, are the left/right turns from the root.
    for (int d = 0; d < int'(WayW); d++) begin
      node = (32'd1 << d) - 32'd1 + (32'(way_i) >> (WayW - 32'(d)));
      tree_o[node] = ~way_i[WayW-1-d];
    end
    victim_o = '0;
    node     = 0;
    for (int d = 0; d < int'(WayW); d++) begin
      victim_o[WayW-1-d] = tree_i[node];
      node = 2 * node + 1 + 32'(tree_i[node]);
    end
  end

endmodule

// File: rtl/cache_nway_wb.sv
// N-way set-associative, write-back, write-allocate cache with tree pseudo-LRU replacement
// and saturating hit/miss counters.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   mem_*_i / mem_*_o   - CPU port: read/write held until mem_resp_o; rdata valid with resp
//   pmem_*_o / pmem_*_i - memory port: whole-line fill (read) and writeback (write)
//   hit_count_o         - hits completed without a refill (saturating)
//   miss_count_o        - misses detected (saturating)
module cache_nway_wb
  import cache_nway_wb_pkg::*;
#(
  parameter int unsigned WAYS       = 4,
  parameter int unsigned SETS       = 8,
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned ADDR_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mem_read_i,
  input  logic                    mem_write_i,
  input  logic [ADDR_W-1:0]       mem_address_i,
  input  logic [15:0]             mem_wdata_i,
  input  logic [1:0]              mem_byte_enable_i,
  output logic [15:0]             mem_rdata_o,
  output logic                    mem_resp_o,
  output logic                    pmem_read_o,
  output logic                    pmem_write_o,
  output logic [ADDR_W-1:0]       pmem_address_o,
  output logic [16*LINE_WORDS-1:0] pmem_wdata_o,
  input  logic [16*LINE_WORDS-1:0] pmem_rdata_i,
  input  logic                    pmem_resp_i,
  output logic [15:0]             hit_count_o,
  output logic [15:0]             miss_count_o
);

  localparam int unsigned OffW  = $clog2(2 * LINE_WORDS);
  localparam int unsigned IdxW  = $clog2(SETS);
  localparam int unsigned TagW  = ADDR_W - IdxW - OffW;
  localparam int unsigned WayW  = $clog2(WAYS);
  localparam int unsigned LineW = 16 * LINE_WORDS;

  cache_state_t state_q, state_d;

  logic [TagW-1:0]  tag_q   [WAYS][SETS];
  logic [LineW-1:0] data_q  [WAYS][SETS];
  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAYS-1:0]  dirty_q [SETS];
  logic [WAYS-2:0]  plru_q  [SETS];

  logic [WayW-1:0] victim_q, victim_d;
  logic            refill_q, refill_d;
  logic [15:0]     hit_q, miss_q;

  logic [TagW-1:0] req_tag;
  logic [IdxW-1:0] idx;
  logic [OffW-2:0] sel;
  logic            req, unused_addr;

  assign req_tag     = mem_address_i[ADDR_W-1 -: TagW];
  assign idx         = mem_address_i[OffW +: IdxW];
  assign sel         = mem_address_i[OffW-1:1];
  assign req         = mem_read_i | mem_write_i;
  assign unused_addr = mem_address_i[0];

  logic            hit, inv_found;
  logic [WayW-1:0] hit_way, inv_way, plru_victim, miss_victim;
  logic [WAYS-2:0] plru_upd;

  // Descending scan leaves the lowest matching index.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (valid_q[idx][w] && (tag_q[w][idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WayW'(w);
      end
      if (!valid_q[idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WayW'(w);
      end
    end
  end

  assign miss_victim = inv_found ? inv_way : plru_victim;

  cache_nway_wb_plru #(
    .Ways(WAYS)
  ) u_plru (
    .tree_i   (plru_q[idx]),
    .way_i    (hit_way),
    .tree_o   (plru_upd),
    .victim_o (plru_victim)
  );

  logic [LineW-1:0] hit_line, wr_line;
  logic [15:0]      old_word, wr_word;

  always_comb begin
    hit_line = data_q[hit_way][idx];
    old_word = hit_line[{sel, 4'b0000} +: 16];
    wr_word  = old_word;
    if (mem_byte_enable_i[0]) wr_word[7:0]  = mem_wdata_i[7:0];
    if (mem_byte_enable_i[1]) wr_word[15:8] = mem_wdata_i[15:8];
    wr_line = hit_line;
    wr_line[{sel, 4'b0000} +: 16] = wr_word;
  end

  assign mem_rdata_o  = old_word;
  assign pmem_wdata_o = data_q[victim_q][idx];

  logic do_hit, do_miss, fill_done;

  always_comb begin
    state_d        = state_q;
    victim_d       = victim_q;
    refill_d       = refill_q;
    mem_resp_o     = 1'b0;
    pmem_read_o    = 1'b0;
    pmem_write_o   = 1'b0;
    pmem_address_o = '0;
    do_hit         = 1'b0;
    do_miss        = 1'b0;
    fill_done      = 1'b0;
    unique case (state_q)
      StCheck: begin
        if (req && hit) begin
          mem_resp_o = 1'b1;
          do_hit     = 1'b1;
          refill_d   = 1'b0;
        end else if (req) begin
          do_miss  = 1'b1;
          refill_d = 1'b1;
          victim_d = miss_victim;
          state_d  = (valid_q[idx][miss_victim] && dirty_q[idx][miss_victim]) ?
                     StWriteback : StFill;
        end
      end
      StWriteback: begin
        pmem_write_o   = 1'b1;
        pmem_address_o = {tag_q[victim_q][idx], idx, {OffW{1'b0}}};
        if (pmem_resp_i) state_d = StFill;
      end
      StFill: begin
        pmem_read_o    = 1'b1;
        pmem_address_o = {req_tag, idx, {OffW{1'b0}}};
        if (pmem_resp_i) begin
          fill_done = 1'b1;
          state_d   = StCheck;
        end
      end
      default: state_d = StCheck;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StCheck;
      victim_q <= '0;
      refill_q <= 1'b0;
      hit_q    <= '0;
      miss_q   <= '0;
      for (int s = 0; s < int'(SETS); s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      refill_q <= refill_d;
      if (do_hit) plru_q[idx] <= plru_upd;
      if (do_hit && mem_write_i) dirty_q[idx][hit_way] <= 1'b1;
      if (fill_done) begin
        valid_q[idx][victim_q] <= 1'b1;
        dirty_q[idx][victim_q] <= 1'b0;
      end
      if (do_miss && (miss_q != 16'hFFFF)) miss_q <= miss_q + 16'd1;
      // The completion that follows a refill is the tail of a miss, not a hit.
      if (do_hit && !refill_q && (hit_q != 16'hFFFF)) hit_q <= hit_q + 16'd1;
    end
  end

  // Tag and data arrays carry no reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_q[victim_q][idx]  <= req_tag;
      data_q[victim_q][idx] <= pmem_rdata_i;
    end else if (do_hit && mem_write_i) begin
      data_q[hit_way][idx] <= wr_line;
    end
  end

  assign hit_count_o  = hit_q;
  assign miss_count_o = miss_q;

endmodule
